fetch_frontend: RTL and testbench

- Parametrised instruction-fetch front end for the pipelined core. It replaces the single-cycle PC register and fetch pair with a PC generator, an ibus handshake FSM and a DEPTH-entry instruction queue.
- It tolerates multi-cycle ibus latency and absorbs decode stalls.
- Redirects from decode or execute flush the queue and kill any in-flight fetch.
- The output feeds the fetch/decode pipeline register through a valid/ready interface.

---
 rtl/fetch_frontend_pkg.sv | 28 ++
 rtl/fetch_frontend_inst_queue.sv | 56 +++++
 rtl/fetch_frontend.sv | 79 +++++++
 tb/tb_fetch_frontend.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_frontend_pkg.sv
// fetch_frontend_pkg: shared ibus, fetch-state and queue-entry types for the fetch front end
package fetch_frontend_pkg;

    localparam int BUS_AW = 64;

    typedef struct packed {
        logic              valid;
        logic [BUS_AW-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t IDLE  = 2'd0;
    localparam fetch_state_t BUSY  = 2'd1;
    localparam fetch_state_t DRAIN = 2'd2;

    typedef struct packed {
        logic [BUS_AW-1:0] pc;
        logic [31:0]       instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_frontend_inst_queue.sv
// fetch_frontend_inst_queue: DEPTH-entry circular FIFO of fetched {pc, instr} entries with flush
module fetch_frontend_inst_queue
    import fetch_frontend_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    input  fetch_entry_t            wdata_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output fetch_entry_t            head_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pop;

    // an empty queue ignores pop; the producer never pushes into a full queue
    assign pop     = pop_i && count_q != '0;
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // pointer and occupancy update; flush wins over push and pop
    always_comb begin
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + AW'(push_i);
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + AW'(pop);
        count_d  = flush_i ? '0 : count_q + (AW+1)'(push_i) - (AW+1)'(pop);
    end

    // pointer and occupancy registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // entry storage; contents are only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (push_i && !flush_i)
            mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_frontend.sv
// fetch_frontend: PC generator, single-outstanding ibus handshake FSM and instruction queue
module fetch_frontend
    import fetch_frontend_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            reset,
    output ibus_req_t       ireq,
    input  ibus_resp_t      iresp,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
);

    localparam int AW = $clog2(DEPTH);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] target_pc;
    logic [AW:0]     count;
    logic            full, start, push, unused;
    fetch_entry_t    head, wr_entry;

    // redirect targets are forced to a 4-byte boundary
    assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};
    assign full      = count == (AW+1)'(DEPTH);
    assign start     = state_q == IDLE && !redirect_valid && !full;
    assign push      = state_q == BUSY && iresp.data_ok && !redirect_valid;
    assign wr_entry  = '{pc: BUS_AW'(req_addr_q), instr: iresp.data};
    assign unused    = iresp.addr_ok;

    assign ireq      = '{valid: state_q == BUSY || state_q == DRAIN, addr: BUS_AW'(req_addr_q)};
    assign out_valid = count != '0;
    assign out_pc    = out_valid ? XLEN'(head.pc) : '0;
    assign out_instr = out_valid ? head.instr : '0;

    // next state, next fetch PC and the address latched when a request starts
    always_comb begin
        state_d    = state_q == IDLE ? (start ? BUSY : IDLE)
                   : iresp.data_ok ? IDLE
                   : state_q == BUSY && !redirect_valid ? BUSY : DRAIN;
        fetch_pc_d = redirect_valid ? target_pc : push ? req_addr_q + XLEN'(4) : fetch_pc_q;
        req_addr_d = start ? fetch_pc_q : req_addr_q;
    end

    // FSM, fetch PC and held request address registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    fetch_frontend_inst_queue #(
        .DEPTH(DEPTH)
    ) u_inst_queue (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (out_ready),
        .flush_i (redirect_valid),
        .wdata_i (wr_entry),
        .count_o (count),
        .head_o  (head)
    );

endmodule

// File: tb/tb_fetch_frontend.sv
// tb_fetch_frontend: randomized ibus/decode stimulus checked against a queue-based fetch-stream model
module tb_fetch_frontend;
    import fetch_frontend_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    ibus_req_t   ireq;
    ibus_resp_t  iresp = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;

    int          n_total = 0;
    int          n_pass = 0;
    exp_t        q[$];
    logic [63:0] next_req, prev_addr, force_pc;
    logic        killed, prev_valid, prev_done;
    int          wait_n, lat, lat_lo, lat_hi, ready_pct, redir_pml, hs_cnt;
    bit          force_redir, arm4, hit4, found;

    fetch_frontend #(
        .DEPTH(DEPTH),
        .XLEN(64),
        .RESET_PC(RST_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [63:0] rand_target();
        logic [63:0] t = {$urandom, $urandom};
        return ($urandom_range(3) == 0) ? {60'hFFF_FFFF_FFFF_FFFF, t[3:0]} : {48'h0000_8000_0000 >> 16, t[15:0]} | 64'h8000_0000;
    endfunction

    task automatic model_reset();
        q.delete();
        next_req   = RST_PC;
        killed     = 1'b0;
        prev_valid = 1'b0;
        prev_done  = 1'b0;
        prev_addr  = '0;
        wait_n     = 0;
        lat        = $urandom_range(lat_hi, lat_lo);
    endtask

    // compare the pre-edge DUT view with the model, then advance the model across the edge
    task automatic score();
        bit fresh, acc;
        fresh = ireq.valid && (!prev_valid || prev_done);
        check("occupancy_le_depth", 64'(q.size() <= DEPTH), 64'd1);
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_pc", out_pc, q[0].pc);
            check("out_instr", 64'(out_instr), 64'(q[0].instr));
        end
        check("no_req_when_full", 64'(ireq.valid && q.size() == DEPTH), 64'd0);
        if (prev_valid && !prev_done) begin
            check("req_held_valid", 64'(ireq.valid), 64'd1);
            check("req_held_addr", ireq.addr, prev_addr);
        end else if (fresh) begin
            check("req_addr", ireq.addr, next_req);
        end
        if (q.size() != 0 && out_ready) begin
            void'(q.pop_front());
            hs_cnt++;
        end
        acc = ireq.valid && iresp.data_ok && !killed && !redirect_valid;
        if (redirect_valid) begin
            q.delete();
            next_req = {redirect_pc[63:2], 2'b00};
            killed   = ireq.valid && !iresp.data_ok;
        end else begin
            if (acc) begin
                q.push_back('{next_req, mem_word(next_req)});
                next_req += 64'd4;
            end
            if (iresp.data_ok)
                killed = 1'b0;
        end
        if (ireq.valid && iresp.data_ok) begin
            wait_n = 0;
            lat    = $urandom_range(lat_hi, lat_lo);
        end else if (ireq.valid) begin
            wait_n++;
        end
        prev_valid = ireq.valid;
        prev_done  = iresp.data_ok;
        prev_addr  = ireq.addr;
    endtask

    task automatic tick();
        @(negedge clk);
        iresp.addr_ok  = ireq.valid;
        iresp.data_ok  = ireq.valid && wait_n >= lat;
        iresp.data     = mem_word(ireq.addr);
        out_ready      = $urandom_range(99) < ready_pct;
        redirect_valid = force_redir || ($urandom_range(999) < redir_pml);
        redirect_pc    = force_redir ? force_pc : rand_target();
        force_redir    = 1'b0;
        if (arm4 && q.size() == 3 && iresp.data_ok && !killed) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            out_ready      = 1'b1;
            arm4           = 1'b0;
            hit4           = 1'b1;
        end
        #1;
        score();
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        check("rst_ireq_valid", 64'(ireq.valid), 64'd0);
        check("rst_ireq_addr", ireq.addr, RST_PC);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        iresp          = '0;
        release_reset();
    endtask

    initial begin
        lat_lo = 0; lat_hi = 0; ready_pct = 100; redir_pml = 0;
        force_redir = 1'b0; arm4 = 1'b0; hit4 = 1'b0; force_pc = '0; hs_cnt = 0;
        model_reset();

        // zero-wait bus, decode always ready: sequential stream at one entry per two cycles
        do_reset();
        check("first_req_before_edge", 64'(ireq.valid), 64'd0);
        tick();
        check("first_req_latency", 64'(ireq.valid), 64'd1);
        hs_cnt = 0;
        repeat (40) tick();
        check("t1_rate", 64'(hs_cnt >= 19 && hs_cnt <= 20), 64'd1);

        // decode stalled: queue fills to DEPTH and fetching stops, then drains in order
        do_reset();
        ready_pct = 0;
        repeat (20) tick();
        check("t2_entries", 64'(q.size()), 64'(DEPTH));
        check("t2_no_req", 64'(ireq.valid), 64'd0);
        check("t2_head_pc", out_pc, RST_PC);
        ready_pct = 100;
        repeat (30) tick();

        // slow bus with a redirect while busy: in-flight data is dropped, refetch at target
        lat_lo = 5; lat_hi = 5;
        do_reset();
        for (int i = 0; i < 20 && !(ireq.valid && wait_n == 2); i++) tick();
        check("t3_busy", 64'(ireq.valid), 64'd1);
        force_redir = 1'b1;
        force_pc    = 64'h8000_1000;
        tick();
        tick();
        check("t3_drain_hold", ireq.addr, RST_PC);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            found = ireq.valid && ireq.addr == 64'h8000_1000;
        end
        check("t3_refetch", 64'(found), 64'd1);
        repeat (20) tick();

        // redirect coincident with data_ok and a pop while three entries are queued
        lat_lo = 0; lat_hi = 0; ready_pct = 0;
        do_reset();
        arm4 = 1'b1; hit4 = 1'b0; force_pc = 64'h8000_2000;
        for (int i = 0; i < 40 && !hit4; i++) tick();
        check("t4_hit", 64'(hit4), 64'd1);
        arm4 = 1'b0;
        tick();
        check("t4_flushed", 64'(out_valid), 64'd0);
        ready_pct = 100;
        repeat (12) tick();

        // simultaneous push and pop across the pointer wrap
        ready_pct = 0;
        do_reset();
        repeat (5) tick();
        ready_pct = 100;
        hs_cnt = 0;
        repeat (20) tick();
        check("t5_handshakes", 64'(hs_cnt >= 10), 64'd1);

        // asynchronous reset while a request is outstanding
        lat_lo = 5; lat_hi = 5;
        do_reset();
        repeat (3) tick();
        check("t6_busy", 64'(ireq.valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_async_valid", 64'(ireq.valid), 64'd0);
        check("t6_async_addr", ireq.addr, RST_PC);
        check("t6_async_out_valid", 64'(out_valid), 64'd0);
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        iresp          = '0;
        release_reset();
        repeat (20) tick();

        // randomized latency, stalls and redirects (including wrap-around targets)
        lat_lo = 0; lat_hi = 4; ready_pct = 70; redir_pml = 30;
        do_reset();
        repeat (3000) tick();
        lat_lo = 0; lat_hi = 1; ready_pct = 95; redir_pml = 15;
        repeat (1000) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
